bool_sweep_ctrl: RTL and testbench
==================================

Name: bool_sweep_ctrl

Overview:
- Sequencer that exhaustively drives an external N-input combinational boolean function under test.
- Walks all 2^N input vectors, samples the function output y and assembles a truth table.
- Compares the table against a golden table and reports pass/fail, mismatch count and first failing index.
- Sits beside the combinational function blocks as their on-chip self-check engine, replacing hand-written vector sweeps.

Parameters:
- N_IN, 4, number of function inputs; vec_out bit N_IN-1 drives input a (MSB), bit 0 drives d for the 4-input case.
- SETTLE, 1, extra wait cycles each vector is held before y is sampled (0 allowed).
- TW, 2**N_IN, truth-table width (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin sweep; accepted only in IDLE.
- abort  input  1  cancel sweep; return to IDLE.
- expected  input  TW  golden truth table; bit i = f(vector i).
- y  input  1  output of the function under test.
- vec_out  output  N_IN  current input vector to the function.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse when sweep completes.
- pass  output  1  table_out == expected; valid from done until next start.
- table_out  output  TW  captured truth table.
- mismatch_cnt  output  N_IN+1  number of differing bits.
- first_fail  output  N_IN  lowest failing index; 0 when pass.

Behaviour:
- Reset (rst high at clk edge): state IDLE; vec_out=0, busy=0, done=0, pass=0, table_out=0, mismatch_cnt=0, first_fail=0, settle counter=0.
- States: IDLE, HOLD, EVAL, DONE.
- IDLE: start=1 -> latch expected into an internal copy, clear table_out/mismatch_cnt/first_fail/pass, vec_out=0, settle counter=0, busy=1 -> HOLD. Later changes to expected during the sweep are ignored.
- HOLD: vec_out held stable for SETTLE+1 cycles, counted by the settle counter.
- On the last HOLD cycle edge: table_out[vec_out] <= y.
  - If y != latched expected[vec_out]: mismatch_cnt += 1.
  - If it is the first mismatch: first_fail <= vec_out.
- HOLD exit: if vec_out == TW-1 -> EVAL; else vec_out += 1, counter=0, stay HOLD.
- Sampling edge for vector i: (i+1)*(SETTLE+1) edges after the start-accept edge.
- EVAL: one cycle; pass <= (mismatch_cnt == 0); vec_out <= 0 -> DONE.
- DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Latency: done high in the cycle after edge TW*(SETTLE+1)+1 counted from the start-accept edge. Example: N_IN=4, SETTLE=1 -> edge 33.
- Results hold in IDLE until the next accepted start.
- vec_out is 0 whenever not in HOLD.
- start while busy: ignored, no restart.
- start in the DONE cycle: ignored; must be reasserted in IDLE.
- abort: highest priority after rst. In HOLD/EVAL -> IDLE next edge; busy=0, vec_out=0, done not pulsed, pass=0. table_out/mismatch_cnt keep their partial values (debug only).
- start and abort together in IDLE: abort wins, no sweep.
- rst mid-sweep: full reset values next edge; no done.
- Width rules:
  - mismatch_cnt saturation is not needed; max value TW fits in N_IN+1 bits.
  - vec_out increment never wraps inside a sweep; the last index is detected explicitly.

Test Plan:
- DUT f=(a&b)|(~c&d), N_IN=4, SETTLE=1, expected=16'hF222, start pulse -> vec_out steps 0..15, two cycles each. Done pulse after edge 33; table_out=16'hF222, pass=1, mismatch_cnt=0, first_fail=0.
- Same DUT, expected=16'hF223 -> table_out=16'hF222, pass=0, mismatch_cnt=1, first_fail=0.
- expected=16'h0DDD (all bits inverted) -> mismatch_cnt=16, pass=0, first_fail=0. Repeat with SETTLE=0 -> done after edge 17.
- Assert start again at vector 5, and toggle expected mid-sweep -> no restart; results identical to scenario 1.
- abort at vector 7 -> IDLE next edge, busy=0, vec_out=0, no done pulse, pass=0. A subsequent start runs a full sweep and gives pass=1.
- rst at vector 10 -> all outputs at reset values next edge. start together with abort in IDLE -> stays IDLE, busy stays 0.

Source files
------------

// File: rtl/bool_sweep_ctrl.sv
// Exhaustive sweep engine for an N-input combinational function: drives every
// input vector, captures the truth table and grades it against a golden table.
module bool_sweep_ctrl #(
    parameter  int N_IN   = 4,
    parameter  int SETTLE = 1,
    localparam int TW     = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [TW-1:0]   expected,
    input  logic            y,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [TW-1:0]   table_out,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail
);

    localparam int              SW          = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};

    typedef enum logic [1:0] {IDLE, HOLD, EVAL, DONE} state_t;

    state_t          state, state_nxt;
    logic [SW-1:0]   settle_cnt;
    logic [TW-1:0]   exp_q;
    logic            accept;
    logic            abort_now;
    logic            sample_now;

    // abort outranks start in IDLE, and only cancels an active sweep otherwise
    assign accept     = (state == IDLE) && start && !abort;
    assign abort_now  = abort && ((state == HOLD) || (state == EVAL));
    assign sample_now = (state == HOLD) && (settle_cnt == SETTLE_LAST);

    assign busy = (state == HOLD) || (state == EVAL);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = HOLD;
            HOLD: begin
                if (abort)                                state_nxt = IDLE;
                else if (sample_now && vec_out == LAST_VEC) state_nxt = EVAL;
            end
            EVAL:    state_nxt = abort ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // expected is snapshotted at start so the golden table cannot move mid-sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out      <= '0;
            settle_cnt   <= '0;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (accept) begin
            exp_q        <= expected;
            vec_out      <= '0;
            settle_cnt   <= '0;
            pass         <= 1'b0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else if (abort_now) begin
            vec_out    <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (sample_now) begin
                        table_out[vec_out] <= y;
                        if (y != exp_q[vec_out]) begin
                            mismatch_cnt <= mismatch_cnt + 1'b1;
                            if (mismatch_cnt == '0) first_fail <= vec_out;
                        end
                        // last index detected explicitly; vec_out parks at 0 outside HOLD
                        vec_out    <= (vec_out == LAST_VEC) ? '0 : vec_out + 1'b1;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    pass    <= (mismatch_cnt == '0);
                    vec_out <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// Self-checking bench for bool_sweep_ctrl with a scoreboard of sweep results,
// exercising SETTLE=1 and SETTLE=0 instances against f=(a&b)|(~c&d).
module tb_bool_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s, abort_s;
    logic        cur;
    logic [15:0] expected;

    logic        start0, abort0, start1, abort1;
    logic        y0, y1;
    logic [3:0]  vo0, vo1, ff0, ff1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] tbl0, tbl1;
    logic [4:0]  cnt0, cnt1;

    logic [3:0]  vo, ffo;
    logic        busy, done, pass;
    logic [15:0] tbl;
    logic [4:0]  cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] tbl;
        logic        pass;
        logic [4:0]  cnt;
        logic [3:0]  ff;
        int          lat;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    function automatic logic f_model(logic [3:0] v);
        return (v[3] & v[2]) | (~v[1] & v[0]);
    endfunction

    assign y0     = f_model(vo0);
    assign y1     = f_model(vo1);
    assign start0 = cur ? 1'b0 : start_s;
    assign abort0 = cur ? 1'b0 : abort_s;
    assign start1 = cur ? start_s : 1'b0;
    assign abort1 = cur ? abort_s : 1'b0;
    assign vo     = cur ? vo1 : vo0;
    assign ffo    = cur ? ff1 : ff0;
    assign busy   = cur ? busy1 : busy0;
    assign done   = cur ? done1 : done0;
    assign pass   = cur ? pass1 : pass0;
    assign tbl    = cur ? tbl1 : tbl0;
    assign cnt    = cur ? cnt1 : cnt0;

    bool_sweep_ctrl #(.N_IN(4), .SETTLE(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0), .expected(expected),
        .y(y0), .vec_out(vo0), .busy(busy0), .done(done0), .pass(pass0),
        .table_out(tbl0), .mismatch_cnt(cnt0), .first_fail(ff0)
    );

    bool_sweep_ctrl #(.N_IN(4), .SETTLE(0)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected),
        .y(y1), .vec_out(vo1), .busy(busy1), .done(done1), .pass(pass1),
        .table_out(tbl1), .mismatch_cnt(cnt1), .first_fail(ff1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(string name);
        checks++;
        if ({vo, busy, done, pass, tbl, cnt, ffo} !== 31'h0) begin
            errors++;
            $display("FAIL %s: vec=%0h busy=%0b done=%0b pass=%0b table=%0h cnt=%0d ff=%0h, required all zero",
                     name, vo, busy, done, pass, tbl, cnt, ffo);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_s = 1'b0; abort_s = 1'b0; expected = 16'h0;
        tick(); tick();
        rst = 1'b0;
        tick();
        cur = 1'b0; #0 check_idle_zero("reset_s1");
        cur = 1'b1; #0 check_idle_zero("reset_s0");
    endtask

    // Drives one sweep; disturb re-asserts start and flips expected at vector 5.
    task automatic test_sweep(string name, bit sel, logic [15:0] exp, bit disturb);
        sb_t e, g;
        int  s1, lat;
        bit  got;
        cur = sel;
        s1  = sel ? 1 : 2;
        e.tbl = '0;
        for (int i = 0; i < 16; i++) e.tbl[i] = f_model(4'(i));
        e.cnt = '0; e.ff = '0;
        for (int i = 15; i >= 0; i--)
            if (e.tbl[i] != exp[i]) begin e.cnt++; e.ff = 4'(i); end
        e.pass = (e.tbl == exp);
        e.lat  = 16 * s1 + 1;
        sb.push_back(e);

        expected = exp;
        start_s  = 1'b1;
        tick();
        start_s  = 1'b0;
        got = 1'b0; lat = -1;
        for (int k = 0; k < 200; k++) begin
            if (done) begin got = 1'b1; lat = k; break; end
            if (k < 16 * s1) begin
                checks++;
                if (vo !== 4'(k / s1) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_step%0d: vec=%0h busy=%0b, required vec=%0h busy=1",
                             name, k, vo, busy, k / s1);
                end
            end
            if (disturb && k == 5 * s1)     begin start_s = 1'b1; expected = ~exp; end
            if (disturb && k == 5 * s1 + 2) start_s = 1'b0;
            tick();
        end
        g = sb.pop_front();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout: no done within 200 cycles, required done at %0d", name, g.lat);
        end else begin
            if (lat != g.lat) begin
                errors++;
                $display("FAIL %s_latency: done after edge %0d, required %0d", name, lat, g.lat);
            end
            checks++;
            if (busy !== 1'b0 || vo !== 4'h0) begin
                errors++;
                $display("FAIL %s_done_state: busy=%0b vec=%0h, required 0/0", name, busy, vo);
            end
            checks++;
            if (tbl !== g.tbl || pass !== g.pass || cnt !== g.cnt || ffo !== g.ff) begin
                errors++;
                $display("FAIL %s_result: table=%0h pass=%0b cnt=%0d ff=%0h, required table=%0h pass=%0b cnt=%0d ff=%0h",
                         name, tbl, pass, cnt, ffo, g.tbl, g.pass, g.cnt, g.ff);
            end
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || tbl !== g.tbl || pass !== g.pass) begin
                errors++;
                $display("FAIL %s_hold: done=%0b busy=%0b table=%0h pass=%0b, required done=0 busy=0 table=%0h pass=%0b",
                         name, done, busy, tbl, pass, g.tbl, g.pass);
            end
        end
        expected = exp;
    endtask

    task automatic wait_vec(string name, logic [3:0] v);
        for (int i = 0; i < 100 && vo !== v; i++) tick();
        checks++;
        if (vo !== v) begin
            errors++;
            $display("FAIL %s_wait: vec=%0h, required %0h", name, vo, v);
        end
    endtask

    task automatic test_abort();
        bit seen;
        cur = 1'b0;
        expected = 16'hF222;
        start_s = 1'b1; tick(); start_s = 1'b0;
        wait_vec("abort", 4'd7);
        abort_s = 1'b1; tick(); abort_s = 1'b0;
        checks++;
        if (busy !== 1'b0 || vo !== 4'h0 || pass !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%0b vec=%0h pass=%0b done=%0b, required all 0", busy, vo, pass, done);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_done: busy/done=1 seen, required 0 after abort");
        end
        test_sweep("after_abort", 1'b0, 16'hF222, 1'b0);
    endtask

    task automatic test_rst_mid();
        bit seen;
        cur = 1'b0;
        expected = 16'hF223;
        start_s = 1'b1; tick(); start_s = 1'b0;
        wait_vec("rstmid", 4'd10);
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle_zero("rst_mid");
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_mid_no_done: busy/done=1 seen, required 0 after reset");
        end
    endtask

    task automatic test_start_abort_idle();
        bit seen;
        cur = 1'b0;
        start_s = 1'b1; abort_s = 1'b1;
        tick();
        start_s = 1'b0; abort_s = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (busy || vo !== 4'h0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL start_abort_idle: busy=1 or vec!=0 seen, required idle");
        end
    endtask

    initial begin
        cur = 1'b0;
        test_reset();
        test_sweep("pass_s1",    1'b0, 16'hF222, 1'b0);
        test_sweep("onebad_s1",  1'b0, 16'hF223, 1'b0);
        test_sweep("allbad_s1",  1'b0, 16'h0DDD, 1'b0);
        test_sweep("allbad_s0",  1'b1, 16'h0DDD, 1'b0);
        test_sweep("pass_s0",    1'b1, 16'hF222, 1'b0);
        test_sweep("disturb_s1", 1'b0, 16'hF222, 1'b1);
        test_abort();
        test_rst_mid();
        test_start_abort_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
